// File: rtl/cdb_issue_scheduler_pkg.sv
// cdb_issue_scheduler_pkg: shared CDB source types and default unit latencies
package cdb_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        INT_FIFO  = 2'd0,
        LDST_FIFO = 2'd1,
        MULT_FIFO = 2'd2,
        DIV_FIFO  = 2'd3
    } fifo_data_type;

    typedef struct packed {
        logic          valid;
        fifo_data_type src;
    } cdb_slot_t;

    localparam int INT_LAT_DEF  = 1;
    localparam int LDST_LAT_DEF = 1;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 8;
    localparam int DEPTH_DEF    = 8;

endpackage

// File: rtl/cdb_slot_table.sv
// cdb_slot_table: shift register of future CDB owners; slot k is k cycles ahead
module cdb_slot_table
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        clear_i,
    input  cdb_slot_t [DEPTH-1:0]       ins_i,
    output cdb_slot_t [DEPTH-1:0]       slot_o
);

    cdb_slot_t [DEPTH-1:0] slot_q;
    cdb_slot_t [DEPTH-1:0] shift_d;

    // Advance every reservation one cycle closer; the far end refills empty
    always_comb begin
        shift_d = '0;
        for (int k = 0; k < DEPTH - 1; k++) shift_d[k] = slot_q[k+1];
    end

    // A new reservation only ever targets a slot that is empty after the shift
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++)
            slot_q[k] <= clear_i ? '0 : (ins_i[k].valid ? ins_i[k] : shift_d[k]);
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: grants issue to the four queues while reserving their CDB write-back slot
module cdb_issue_scheduler
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT  = INT_LAT_DEF,
    parameter int LDST_LAT = LDST_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_issue_rdy,
    input  logic       ldst_issue_rdy,
    input  logic       mult_issue_rdy,
    input  logic       div_issue_rdy,
    input  logic       flush,
    output logic       int_issue_grant,
    output logic       ldst_issue_grant,
    output logic       mult_issue_grant,
    output logic       div_issue_grant,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid,
    output logic       div_busy
);

    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    if (INT_LAT < 1 || LDST_LAT < 1 || MULT_LAT < 1 || DIV_LAT < 1 ||
        INT_LAT > DEPTH || LDST_LAT > DEPTH || MULT_LAT > DEPTH || DIV_LAT > DEPTH) begin : g_bad_lat
        $error("cdb_issue_scheduler: every latency must be within 1..DEPTH");
    end

    cdb_slot_t [DEPTH-1:0] slot;
    cdb_slot_t [DEPTH-1:0] ins;
    logic [DEPTH:0]        taken;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  rr_q, rr_d;
    logic                  blk, int_el, ldst_el;

    assign blk = rst | flush;

    cdb_slot_table #(.DEPTH(DEPTH)) u_slots (
        .clk     (clk),
        .clear_i (blk),
        .ins_i   (ins),
        .slot_o  (slot)
    );

    // Claim write-back slots in priority order DIV > MULT > INT/LD_ST; each claim hides the slot from later units
    always_comb begin
        taken = '0;
        for (int k = 0; k < DEPTH; k++) taken[k] = slot[k].valid;
        ins = '0;
        div_issue_grant = div_issue_rdy && !blk && div_cnt_q == '0 && !taken[DIV_LAT];
        if (div_issue_grant) begin
            taken[DIV_LAT] = 1'b1;
            ins[DIV_LAT-1] = '{valid: 1'b1, src: DIV_FIFO};
        end
        mult_issue_grant = mult_issue_rdy && !blk && !taken[MULT_LAT];
        if (mult_issue_grant) begin
            taken[MULT_LAT] = 1'b1;
            ins[MULT_LAT-1] = '{valid: 1'b1, src: MULT_FIFO};
        end
        int_el  = int_issue_rdy && !blk && !taken[INT_LAT];
        ldst_el = ldst_issue_rdy && !blk && !taken[LDST_LAT];
        int_issue_grant  = 1'b0;
        ldst_issue_grant = 1'b0;
        if (!rr_q) begin
            int_issue_grant = int_el;
            if (int_issue_grant) begin
                taken[INT_LAT] = 1'b1;
                ins[INT_LAT-1] = '{valid: 1'b1, src: INT_FIFO};
            end
            ldst_issue_grant = ldst_el && !taken[LDST_LAT];
            if (ldst_issue_grant) ins[LDST_LAT-1] = '{valid: 1'b1, src: LDST_FIFO};
        end else begin
            ldst_issue_grant = ldst_el;
            if (ldst_issue_grant) begin
                taken[LDST_LAT] = 1'b1;
                ins[LDST_LAT-1] = '{valid: 1'b1, src: LDST_FIFO};
            end
            int_issue_grant = int_el && !taken[INT_LAT];
            if (int_issue_grant) ins[INT_LAT-1] = '{valid: 1'b1, src: INT_FIFO};
        end
        rr_d = (int_el && ldst_el && (int_issue_grant != ldst_issue_grant)) ? int_issue_grant : rr_q;
        div_cnt_d = div_issue_grant ? CW'(DIV_LAT - 1) : div_cnt_q - CW'(div_cnt_q != '0);
    end

    // Divider occupancy counter and INT/LD_ST tie-breaker; flush keeps the tie-breaker
    always_ff @(posedge clk) begin
        div_cnt_q <= blk ? '0 : div_cnt_d;
        rr_q      <= rst ? 1'b0 : (flush ? rr_q : rr_d);
    end

    assign cdb_sel       = slot[0].src;
    assign cdb_sel_valid = slot[0].valid;
    assign div_busy      = div_cnt_q != '0;

endmodule

// File: doc/cdb_issue_scheduler.md
Name: cdb_issue_scheduler

Overview:
- Issue-stage arbiter for the out-of-order core. Decides each cycle which reservation-station queues (INT, LD_ST, MULT, DIV) may issue to their execution units.
- Shares the single common data bus (cdb_bfm) by reserving its future write-back slot for every granted op.
- Drives the CDB source mux select. Sits between the queues' issue_rdy outputs and the execution units / CDB mux.

Parameters:
- INT_LAT, 1, cycles from INT issue to CDB write-back.
- LDST_LAT, 1, cycles from LD_ST issue to CDB write-back.
- MULT_LAT, 4, cycles from MULT issue to CDB; multiplier fully pipelined.
- DIV_LAT, 8, cycles from DIV issue to CDB; divider non-pipelined.
- DEPTH, 8, reservation-table depth. Must be >= every *_LAT. Every *_LAT must be >= 1 (elaboration assertion).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- int_issue_rdy  in  1  INT queue has a ready entry.
- ldst_issue_rdy  in  1  LD_ST queue has a ready entry.
- mult_issue_rdy  in  1  MULT queue has a ready entry.
- div_issue_rdy  in  1  DIV queue has a ready entry.
- flush  in  1  retire_bus.flush; kills all in-flight ops.
- int_issue_grant  out  1  INT queue issues this cycle.
- ldst_issue_grant  out  1  LD_ST queue issues this cycle.
- mult_issue_grant  out  1  MULT queue issues this cycle.
- div_issue_grant  out  1  DIV queue issues this cycle.
- cdb_sel  out  2  fifo_data_type owning the CDB this cycle.
- cdb_sel_valid  out  1  CDB carries a result this cycle.
- div_busy  out  1  divider occupied.

Behaviour:
- State:
  - Reservation table slot[0..DEPTH-1], each entry {valid, fifo_data_type src}. slot[k] describes CDB ownership k cycles from now. slot[0] is the current cycle's owner.
  - div_cnt, width clog2(DEPTH).
  - rr bit: INT/LD_ST tie-breaker; 0 = INT preferred.
- Grants are combinational, same cycle as rdy; the queue pops on grant. Zero-cycle grant latency.
- Eligibility of unit U with latency L: U_issue_rdy && !slot[L].valid && !flush. DIV additionally requires div_cnt == 0.
- Priority order: DIV > MULT > (INT/LD_ST by rr).
  - Granting is sequential within the cycle: a granted unit claims slot[L], and later units in the order see that slot as taken. This handles equal-latency parameters.
  - At most one grant per queue per cycle. Several grants per cycle are allowed when latencies differ.
- rr toggles only when INT and LD_ST were both eligible and one was granted. It points to the loser.
- Clock edge (no rst, no flush):
  - slot[k] <= slot[k+1], OR'd with new grants targeting index k+1.
  - slot[DEPTH-1] <= new grant with L == DEPTH, else invalid.
- cdb_sel / cdb_sel_valid are registered: they equal slot[0].src / slot[0].valid. An op granted at cycle t appears as cdb_sel_valid at cycle t+L.
- div_cnt:
  - Loaded with DIV_LAT-1 on a div grant.
  - Otherwise decrements while nonzero.
  - div_busy = (div_cnt != 0).
  - Back-to-back divs are DIV_LAT cycles apart.
- flush:
  - In the flush cycle all grants are 0 and cdb_sel_valid is still driven from slot[0].
  - At the edge, all slots are invalidated and div_cnt is cleared. rr is kept.
- rst, mid-operation included: same clearing as flush plus rr <= 0. Grants are 0 during rst.
- Reset values: grants 0, cdb_sel = INT_FIFO, cdb_sel_valid 0, div_busy 0.
- Invariant: slot[0] is never written by a grant, because L >= 1. There is never more than one CDB owner per cycle.

Decomposition:
- Shared package (utils):
  - fifo_data_type (existing).
  - New typedef cdb_slot_t {logic valid; fifo_data_type src}.
  - Latency defaults as localparams.
- One natural sub-module: cdb_slot_table. It holds the shift register with insert ports, exposes slot[k] valid/src, and takes a clear input driven by rst|flush.
- The priority/rr logic and div_cnt stay in the top.

Test Plan:
- Post-reset, all four rdy=1 for one cycle (cycle 0) -> grants DIV, MULT, INT at cycle 0; LD_ST denied; rr=1. cdb_sel_valid with cdb_sel = INT@1, MULT@4, DIV@8.
- INT and LD_ST rdy held high for 6 cycles -> grants alternate INT, LD_ST, INT, …; cdb_sel_valid=1 every cycle from cycle 1 with matching src.
- MULT granted at cycle 0, INT rdy only from cycle 3 -> INT denied at cycle 3 (slot[1] held by MULT), granted at cycle 4. CDB: MULT@4, INT@5.
- div_issue_rdy held high -> div grants at cycles 0, 8, 16; div_busy high cycles 1–7 and 9–15.
- MULT+DIV granted at cycle 0, flush at cycle 2 -> no cdb_sel_valid at cycles 4 or 8; div_busy low from cycle 3; a DIV rdy at cycle 3 is granted.
- rst asserted at cycle 3 with slots pending -> all outputs at reset values from cycle 4; INT rdy at cycle 5 is granted and INT appears on the CDB at cycle 6.
